// File: rtl/debounced_input_pio_pkg.sv
// Shared constants for the debounced input port: register addresses and edge polarity encodings.
package debounced_input_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_MASK     = 2'd1;
  localparam logic [1:0] ADDR_CAPTURE  = 2'd2;
  localparam logic [1:0] ADDR_EDGE_POL = 2'd3;

  localparam logic EDGE_FALLING = 1'b0;
  localparam logic EDGE_RISING  = 1'b1;

endpackage

// File: rtl/debounced_input_pio_debounce_channel.sv
// One input channel: two-flop synchroniser, debounce counter and accepted (stable) level.
// rise/fall pulse on the same edge that stable takes the new level.
module debounce_channel
  import debounced_input_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          in_sync;
  logic          accept;

  assign in_sync = sync[1];
  assign accept  = (in_sync != stable) && (cnt == CNT_LAST);
  assign rise    = accept & in_sync;
  assign fall    = accept & ~in_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync   <= {2{RESET_LEVEL}};
      stable <= RESET_LEVEL;
      cnt    <= '0;
    end else begin
      sync <= {sync[0], in_pin};
      // any return to the accepted level restarts the count
      if (in_sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= in_sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/debounced_input_pio.sv
// Debounced, interrupt-capable parallel input port on an Avalon-MM slave.
// DEBOUNCED_INPUT_PIO_IRQ_EN enables the MASK register and irq; otherwise MASK reads 0 and irq is 0.
module debounced_input_pio
  import debounced_input_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_pins,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] events;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] edge_pol;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] clear_mask;
  logic [31:0]      rd_mux;
  logic             bus_write;
  logic             bus_read;
  logic             unused_wdata;

  assign bus_write    = chipselect & write;
  assign bus_read     = chipselect & read;
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .in_pin (in_pins[i]),
      .stable (data[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  always_comb begin
    events = '0;
    for (int i = 0; i < WIDTH; i++) begin
      events[i] = (edge_pol[i] == EDGE_RISING) ? rise[i] : fall[i];
    end
  end

  assign clear_mask = (bus_write && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;

  // events are ORed in after the clear so a same-cycle set wins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      capture  <= '0;
      edge_pol <= '0;
    end else begin
      capture <= (capture & ~clear_mask) | events;
      if (bus_write && address == ADDR_EDGE_POL) edge_pol <= writedata[WIDTH-1:0];
    end
  end

`ifdef DEBOUNCED_INPUT_PIO_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask <= '0;
    end else if (bus_write && address == ADDR_MASK) begin
      mask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(capture & mask);
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = data;
      ADDR_MASK:     rd_mux[WIDTH-1:0] = mask;
      ADDR_CAPTURE:  rd_mux[WIDTH-1:0] = capture;
      ADDR_EDGE_POL: rd_mux[WIDTH-1:0] = edge_pol;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (bus_read) begin
      readdata <= rd_mux;
    end
  end

endmodule
